// File: rtl/decode_stage.sv
// Decode stage: parametrised register file with writeback bypass, feeding a
// registered valid/ready output stage with flush and stall-time operand refresh.
module decode_stage #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [31:0]     in_pc,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [31:0]     out_pc,
  output logic [XLEN-1:0] out_rs1,
  output logic [XLEN-1:0] out_rs2
);

  localparam int         IDW     = $clog2(NREG);
  localparam logic [5:0] NREG_ID = 6'(NREG);

  logic [XLEN-1:0] regs [NREG];
  logic            wb_hit;
  logic [4:0]      rs1_id, rs2_id, held_rs1_id, held_rs2_id;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic            accept;

  // A write only lands when it targets a real, non-zero register.
  assign wb_hit = wb_en && (wb_rd != 5'd0) && ({1'b0, wb_rd} < NREG_ID);

  assign rs1_id      = in_instr[19:15];
  assign rs2_id      = in_instr[24:20];
  assign held_rs1_id = out_instr[19:15];
  assign held_rs2_id = out_instr[24:20];

  function automatic logic [XLEN-1:0] read_port(input logic [4:0] s,
                                                input logic [XLEN-1:0] stored,
                                                input logic [4:0] w_rd,
                                                input logic w_en,
                                                input logic [XLEN-1:0] w_data);
    logic [XLEN-1:0] v;
    v = '0;
    if (s != 5'd0 && {1'b0, s} < NREG_ID) begin
      if (BYPASS != 0 && w_en && w_rd == s) v = w_data;
      else                                  v = stored;
    end
    return v;
  endfunction

  // NOTE: every variable driven in always_comb gets a value on all paths, so no latch is inferred.
  always_comb begin
    rs1_val = read_port(rs1_id, regs[rs1_id[IDW-1:0]], wb_rd, wb_en, wb_data);
    rs2_val = read_port(rs2_id, regs[rs2_id[IDW-1:0]], wb_rd, wb_en, wb_data);
  end

  // NOTE: the register file is reset explicitly because architectural state must read 0 after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_hit) begin
      regs[wb_rd[IDW-1:0]] <= wb_data;
    end
  end

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc    <= '0;
      out_rs1   <= '0;
      out_rs2   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_instr <= in_instr;
      out_pc    <= in_pc;
      out_rs1   <= rs1_val;
      out_rs2   <= rs2_val;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end else if (out_valid) begin
      // Stalled: keep held operands coherent with writebacks that land meanwhile.
      if (wb_hit && wb_rd == held_rs1_id) out_rs1 <= wb_data;
      if (wb_hit && wb_rd == held_rs2_id) out_rs2 <= wb_data;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: three instances (default, no bypass, 16 regs)
// share stimulus; each scenario task checks its own hand-computed expectations.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, flush, wb_en, out_ready;
  logic [31:0] in_instr, in_pc, wb_data;
  logic [4:0]  wb_rd;

  logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid, c_in_ready, c_out_valid;
  logic [31:0] a_out_instr, a_out_pc, a_out_rs1, a_out_rs2;
  logic [31:0] b_out_instr, b_out_pc, b_out_rs1, b_out_rs2;
  logic [31:0] c_out_instr, c_out_pc, c_out_rs1, c_out_rs2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .NREG(32), .BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .wb_en(wb_en),
    .wb_rd(wb_rd), .wb_data(wb_data), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_instr(a_out_instr), .out_pc(a_out_pc),
    .out_rs1(a_out_rs1), .out_rs2(a_out_rs2));

  decode_stage #(.XLEN(32), .NREG(32), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .wb_en(wb_en),
    .wb_rd(wb_rd), .wb_data(wb_data), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_instr(b_out_instr), .out_pc(b_out_pc),
    .out_rs1(b_out_rs1), .out_rs2(b_out_rs2));

  decode_stage #(.XLEN(32), .NREG(16), .BYPASS(1)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .wb_en(wb_en),
    .wb_rd(wb_rd), .wb_data(wb_data), .out_valid(c_out_valid),
    .out_ready(out_ready), .out_instr(c_out_instr), .out_pc(c_out_pc),
    .out_rs1(c_out_rs1), .out_rs2(c_out_rs2));

  function automatic logic [31:0] mk(input logic [4:0] r1, input logic [4:0] r2,
                                     input logic [6:0] tag);
    return {tag, r2, r1, 3'b000, 5'd1, 7'h13};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; flush = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_pc = '0; wb_rd = '0; wb_data = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick(); tick();
    checks++;
    if (a_out_valid !== 1'b0 || a_out_instr !== 32'h0 || a_out_rs1 !== 32'h0) begin
      errors++; $display("FAIL reset_state: valid=%b instr=%h rs1=%h want 0", a_out_valid, a_out_instr, a_out_rs1);
    end
    checks++;
    if (a_in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b want 1", a_in_ready);
    end
    rst = 1'b0;
    in_valid = 1'b1; in_instr = mk(5'd1, 5'd2, 7'h11); in_pc = 32'h0000_0040;
    tick();
    checks++;
    if (a_out_valid !== 1'b1 || a_out_pc !== 32'h40) begin
      errors++; $display("FAIL pre_reset_capture: valid=%b pc=%h want 1/00000040", a_out_valid, a_out_pc);
    end
    out_ready = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (a_out_valid !== 1'b0 || a_out_pc !== 32'h0 || a_out_instr !== 32'h0 ||
        a_out_rs2 !== 32'h0 || a_in_ready !== 1'b1) begin
      errors++; $display("FAIL async_reset: valid=%b pc=%h instr=%h rs2=%h rdy=%b want 0/0/0/0/1",
                         a_out_valid, a_out_pc, a_out_instr, a_out_rs2, a_in_ready);
    end
    #1;
    rst = 1'b0;
    idle_inputs();
    tick();
  endtask

  task automatic test_write_read();
    wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
    tick();
    wb_en = 1'b0;
    in_valid = 1'b1; in_instr = mk(5'd5, 5'd0, 7'h05); in_pc = 32'h0000_0100;
    tick();
    in_valid = 1'b0;
    checks++;
    if (a_out_valid !== 1'b1 || a_out_rs1 !== 32'hDEADBEEF) begin
      errors++; $display("FAIL write_read_x5: valid=%b rs1=%h want 1/deadbeef", a_out_valid, a_out_rs1);
    end
    wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'h0000_1234;
    tick();
    wb_en = 1'b0;
    in_valid = 1'b1; in_instr = mk(5'd0, 5'd0, 7'h00); in_pc = 32'h0000_0104;
    tick();
    in_valid = 1'b0;
    checks++;
    if (a_out_valid !== 1'b1 || a_out_rs1 !== 32'h0 || a_out_rs2 !== 32'h0) begin
      errors++; $display("FAIL x0_write_ignored: valid=%b rs1=%h rs2=%h want 1/0/0", a_out_valid, a_out_rs1, a_out_rs2);
    end
    tick();
  endtask

  task automatic test_bypass();
    wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'h1111_1111;
    tick();
    wb_data = 32'hA5A5A5A5;
    in_valid = 1'b1; in_instr = mk(5'd7, 5'd7, 7'h07); in_pc = 32'h0000_0200;
    tick();
    in_valid = 1'b0; wb_en = 1'b0;
    checks++;
    if (a_out_rs1 !== 32'hA5A5A5A5 || a_out_rs2 !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL bypass_on: rs1=%h rs2=%h want a5a5a5a5", a_out_rs1, a_out_rs2);
    end
    checks++;
    if (b_out_rs1 !== 32'h1111_1111 || b_out_rs2 !== 32'h1111_1111) begin
      errors++; $display("FAIL bypass_off: rs1=%h rs2=%h want 11111111", b_out_rs1, b_out_rs2);
    end
    tick();
  endtask

  task automatic test_stall_refresh();
    wb_en = 1'b1; wb_rd = 5'd9; wb_data = 32'h0000_0001;
    tick();
    wb_en = 1'b0;
    in_valid = 1'b1; in_instr = mk(5'd3, 5'd9, 7'h09); in_pc = 32'h0000_0300;
    out_ready = 1'b0;
    tick();
    checks++;
    if (a_out_valid !== 1'b1 || a_out_rs2 !== 32'h1 || a_in_ready !== 1'b0) begin
      errors++; $display("FAIL stall_capture: valid=%b rs2=%h rdy=%b want 1/1/0", a_out_valid, a_out_rs2, a_in_ready);
    end
    in_instr = mk(5'd9, 5'd9, 7'h7F); in_pc = 32'h0000_0304;
    wb_en = 1'b1; wb_rd = 5'd9; wb_data = 32'h0000_0055;
    tick();
    wb_en = 1'b0;
    checks++;
    if (a_out_rs2 !== 32'h55 || a_out_rs1 !== 32'h0) begin
      errors++; $display("FAIL stall_refresh: rs1=%h rs2=%h want 0/55", a_out_rs1, a_out_rs2);
    end
    checks++;
    if (b_out_rs2 !== 32'h55) begin
      errors++; $display("FAIL stall_refresh_nobypass: rs2=%h want 55", b_out_rs2);
    end
    checks++;
    if (a_out_instr !== mk(5'd3, 5'd9, 7'h09) || a_out_pc !== 32'h300 || a_in_ready !== 1'b0) begin
      errors++; $display("FAIL stall_hold: instr=%h pc=%h rdy=%b want %h/00000300/0",
                         a_out_instr, a_out_pc, a_in_ready, mk(5'd3, 5'd9, 7'h09));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    checks++;
    if (a_out_valid !== 1'b0) begin
      errors++; $display("FAIL drain: valid=%b want 0", a_out_valid);
    end
  endtask

  task automatic test_flush();
    in_valid = 1'b1; flush = 1'b1; in_instr = mk(5'd11, 5'd0, 7'h0B); in_pc = 32'h0000_0400;
    wb_en = 1'b1; wb_rd = 5'd11; wb_data = 32'h0000_0022;
    #1;
    checks++;
    if (a_in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_in_ready: got %b want 1", a_in_ready);
    end
    tick();
    flush = 1'b0; wb_en = 1'b0; in_valid = 1'b0;
    checks++;
    if (a_out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_drop: valid=%b want 0", a_out_valid);
    end
    in_valid = 1'b1; in_pc = 32'h0000_0404;
    tick();
    in_valid = 1'b0;
    checks++;
    if (a_out_valid !== 1'b1 || a_out_rs1 !== 32'h22) begin
      errors++; $display("FAIL flush_write_kept: valid=%b rs1=%h want 1/22", a_out_valid, a_out_rs1);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_pc;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_instr = mk(5'd0, 5'd0, 7'(i)); in_pc = 32'h0000_0500 + 32'(i * 4);
      #1;
      checks++;
      if (a_in_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, a_in_ready);
      end
      tick();
      exp_pc = 32'h0000_0500 + 32'(i * 4);
      checks++;
      if (a_out_valid !== 1'b1 || a_out_pc !== exp_pc) begin
        errors++; $display("FAIL b2b_out[%0d]: valid=%b pc=%h want 1/%h", i, a_out_valid, a_out_pc, exp_pc);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (a_out_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_end: valid=%b want 0", a_out_valid);
    end
  endtask

  task automatic test_nreg16();
    wb_en = 1'b1; wb_rd = 5'd20; wb_data = 32'h0000_0077;
    tick();
    wb_rd = 5'd15; wb_data = 32'h0000_0003;
    tick();
    wb_en = 1'b0;
    in_valid = 1'b1; in_instr = mk(5'd20, 5'd15, 7'h10); in_pc = 32'h0000_0600;
    tick();
    in_valid = 1'b0;
    checks++;
    if (c_out_valid !== 1'b1 || c_out_rs1 !== 32'h0 || c_out_rs2 !== 32'h3) begin
      errors++; $display("FAIL nreg16: valid=%b rs1=%h rs2=%h want 1/0/3", c_out_valid, c_out_rs1, c_out_rs2);
    end
    checks++;
    if (a_out_rs1 !== 32'h77) begin
      errors++; $display("FAIL nreg32_x20: rs1=%h want 77", a_out_rs1);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_stall_refresh();
    test_flush();
    test_back_to_back();
    test_nreg16();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
